id_bpred_stage: RTL and testbench
=================================

// Module: id_bpred_stage
// PURPOSE
//  Decode stage with a parametrised bimodal branch predictor. It selects the BIOS/IMEM word, reads the
//  register file with WB bypass, and generates immediates. It predicts JAL, JALR and B-type targets for IF,
//  detects load-use hazards, and registers the ID->EX pipeline. The BHT counters are trained by EX branch
//  resolution. Sits between IF and EX of the 5-stage riscv_core.
// PARAMETERS
//  BHT_ENTRIES    64  number of BHT counters; power of 2, >=2; IDX_BITS=$clog2(BHT_ENTRIES)
//  CTR_BITS        2  saturating counter width, >=1
//  INST_SEL_BIT   30  id_pc bit selecting the instruction source (1 = BIOS, 0 = IMEM)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  ex_flush        in   1   EX redirect; squash the instruction in ID
//  id_pc           in  32   PC of instruction in ID
//  id_bios_inst    in  32   BIOS read data
//  id_imem_inst    in  32   IMEM read data
//  wb_regwen       in   1   register write enable from WB
//  wb_inst         in  32   WB instruction (rd = [11:7])
//  wb_wdata        in  32   WB write data
//  ex_alu          in  32   EX ALU result (forward source)
//  mem_alu         in  32   MEM ALU result (forward source)
//  mem_inst        in  32   MEM instruction (hazard/forward decode)
//  ex_br_valid     in   1   EX resolved a B-type this cycle
//  ex_br_pc        in  32   PC of the resolved branch
//  ex_br_outcome   in   1   actual direction (1 = taken)
//  if_pc_target    out 32   predicted next PC for IF
//  if_target_taken out  1   IF uses if_pc_target
//  id_stall        out  1   hold IF/ID; bubble into EX
//  ex_pc, ex_rd1, ex_rd2, ex_imm  out 32 each  registered ID->EX values
//  ex_inst         out 32   registered instruction
//  ex_br_taken     out  1   registered prediction sent to EX
// BEHAVIOUR
//  - inst = id_pc[INST_SEL_BIT] ? id_bios_inst : id_imem_inst. Combinational.
//  - Register read:
//    - rd1/rd2 = wb_wdata when wb_regwen && wb_inst[11:7]==ra && ra!=0.
//    - Otherwise rd1/rd2 = reg_file output. x0 reads 0.
//  - Load-use stall: id_stall=1 when ex_inst is a LOAD with rd!=0 and rd equals the rs1 or rs2 used by inst.
//    JALR also stalls when its rs1 equals a MEM-stage LOAD rd (rd!=0).
//  - JALR rs1 forwarding priority: ex_alu (ex_inst writes rs1) > mem_alu > wb_wdata > rd1. Sources only
//    count for non-zero rd and for instructions that write rd.
//  - BHT: BHT_ENTRIES x CTR_BITS flops. Index = pc[IDX_BITS+1:2]. Prediction is the counter MSB.
//    Reset value of every counter = 2^(CTR_BITS-1)-1 (weakly not-taken).
//  - Target generation (combinational):
//    - JAL: id_pc+immJ, taken=1.
//    - JALR: (fwd_rs1+immI) & ~1, taken=1.
//    - B-type: id_pc+immB, taken = BHT MSB.
//    - All other instructions: taken=0, target=id_pc+4.
//    - if_target_taken is forced 0 when id_stall or ex_flush. All adds wrap mod 2^32.
//  - Training: on ex_br_valid, the counter at idx(ex_br_pc) saturates +1 if ex_br_outcome, else -1.
//    No change at 0 / max. Written at the clock edge.
//    Same-cycle ID read of that index sees the pre-update value (no bypass).
//  - Pipeline regs load every cycle. On id_stall | ex_flush they load a bubble:
//    pc=0, rd1=rd2=imm=0, inst=NOP 32'h0000_0013, ex_br_taken=0.
//    Otherwise they load id_pc, rd1, rd2, imm, inst, and the prediction (1 for JAL/JALR).
//  - Reset (async, any time, including mid-training): all ex_* take bubble values and the BHT is reinitialised.
//    A reset asserted together with ex_br_valid wins.
//  - Latency: prediction 0 cycles (same cycle as ID); ID->EX 1 cycle; BHT update visible next cycle.
// TESTING
//  - Reset then B-type at pc 0x1000, no training: if_target_taken=0; ex_br_taken=0 next cycle;
//    ex_inst matches the instruction.
//  - Two ex_br_valid taken updates at pc 0x1000 -> counter 3. Branch at 0x1000 with immB=-8:
//    if_target_taken=1, if_pc_target=0xFF8. Three not-taken updates -> counter 0 and stays 0 on a fourth.
//  - Aliasing: 0x1000 and 0x1000+4*BHT_ENTRIES share a counter; training one flips the other's prediction.
//  - JALR x1 with ex_inst ADDI x1 (ex_alu=0x2001), imm 4 -> if_pc_target=0x2004.
//    With ex_inst LW x1 instead -> id_stall=1, ex_inst=NOP, if_target_taken=0.
//  - wb_regwen, wb rd=x5, wb_wdata=0xDEADBEEF, ID reads x5 -> ex_rd1=0xDEADBEEF next cycle.
//    The same write to x0 -> ex_rd1=0.
//  - ex_flush with JAL in ID -> if_target_taken=0 and bubble in EX.
//    Async rst pulse mid-cycle -> ex_inst=0x13 immediately and BHT back to 1.

Source files
------------

// File: rtl/id_bpred_if.sv
// ID-stage bundle: fetch words, WB/forward sources, branch training and
// the predicted fetch target plus the registered ID->EX values.
interface id_bpred_if;
  logic        ex_flush;
  logic [31:0] id_pc;
  logic [31:0] id_bios_inst;
  logic [31:0] id_imem_inst;
  logic        wb_regwen;
  logic [31:0] wb_inst;
  logic [31:0] wb_wdata;
  logic [31:0] ex_alu;
  logic [31:0] mem_alu;
  logic [31:0] mem_inst;
  logic        ex_br_valid;
  logic [31:0] ex_br_pc;
  logic        ex_br_outcome;
  logic [31:0] if_pc_target;
  logic        if_target_taken;
  logic        id_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [31:0] ex_inst;
  logic        ex_br_taken;

  modport master (
    output ex_flush, id_pc, id_bios_inst, id_imem_inst,
    output wb_regwen, wb_inst, wb_wdata, ex_alu, mem_alu,
    output mem_inst, ex_br_valid, ex_br_pc, ex_br_outcome,
    input  if_pc_target, if_target_taken, id_stall,
    input  ex_pc, ex_rd1, ex_rd2, ex_imm, ex_inst, ex_br_taken
  );

  modport slave (
    input  ex_flush, id_pc, id_bios_inst, id_imem_inst,
    input  wb_regwen, wb_inst, wb_wdata, ex_alu, mem_alu,
    input  mem_inst, ex_br_valid, ex_br_pc, ex_br_outcome,
    output if_pc_target, if_target_taken, id_stall,
    output ex_pc, ex_rd1, ex_rd2, ex_imm, ex_inst, ex_br_taken
  );
endinterface

// File: rtl/id_bpred_stage.sv
// Decode stage: regfile read with WB bypass, immediates, load-use
// hazard, bimodal branch prediction and the ID->EX register.
module id_bpred_stage #(
  parameter int BHT_ENTRIES  = 64,
  parameter int CTR_BITS     = 2,
  parameter int INST_SEL_BIT = 30
) (
  input logic       clk,
  input logic       rst,
  id_bpred_if.slave bus
);
  localparam int IDX_BITS = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

  function automatic logic wr_rd(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return (op == OP_LOAD || op == OP_IMM || op == OP_AUIPC ||
            op == OP_REG || op == OP_LUI || op == OP_JALR ||
            op == OP_JAL) && i[11:7] != 5'd0;
  endfunction

  logic [31:0] r_rf [32];
  logic [CTR_BITS-1:0] r_bht [BHT_ENTRIES];
  logic [31:0] r_ex_pc, r_ex_rd1, r_ex_rd2, r_ex_imm, r_ex_inst;
  logic        r_ex_br_taken;

  logic [31:0] w_inst, w_rd1, w_rd2, w_fwd, w_imm, w_tgt;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [6:0]  w_op;
  logic [4:0]  w_rs1, w_rs2, w_wb_rd, w_ex_rd, w_mem_rd;
  logic        w_use1, w_use2, w_ex_load, w_mem_load;
  logic        w_stall, w_bubble, w_pred, w_bht_taken;
  logic [IDX_BITS-1:0] w_rd_idx, w_up_idx;
  logic        w_unused;

  assign w_inst   = bus.id_pc[INST_SEL_BIT] ? bus.id_bios_inst
                                            : bus.id_imem_inst;
  assign w_op     = w_inst[6:0];
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];
  assign w_wb_rd  = bus.wb_inst[11:7];
  assign w_ex_rd  = r_ex_inst[11:7];
  assign w_mem_rd = bus.mem_inst[11:7];

  assign w_rd1 = (w_rs1 == 5'd0) ? '0 :
    (bus.wb_regwen && w_wb_rd == w_rs1) ? bus.wb_wdata : r_rf[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? '0 :
    (bus.wb_regwen && w_wb_rd == w_rs2) ? bus.wb_wdata : r_rf[w_rs2];

  always_ff @(posedge clk) begin
    if (bus.wb_regwen && w_wb_rd != 5'd0)
      r_rf[w_wb_rd] <= bus.wb_wdata;
  end

  assign w_use1 = w_op == OP_LOAD || w_op == OP_IMM || w_op == OP_STORE ||
                  w_op == OP_REG || w_op == OP_BR || w_op == OP_JALR;
  assign w_use2 = w_op == OP_STORE || w_op == OP_REG || w_op == OP_BR;
  assign w_ex_load  = r_ex_inst[6:0] == OP_LOAD && w_ex_rd != 5'd0;
  assign w_mem_load = bus.mem_inst[6:0] == OP_LOAD && w_mem_rd != 5'd0;

  assign w_stall =
    (w_ex_load && ((w_use1 && w_rs1 == w_ex_rd) ||
                   (w_use2 && w_rs2 == w_ex_rd))) ||
    (w_op == OP_JALR && w_mem_load && w_mem_rd == w_rs1);
  assign w_bubble = w_stall | bus.ex_flush;

  assign w_fwd =
    (wr_rd(r_ex_inst) && w_ex_rd == w_rs1)     ? bus.ex_alu :
    (wr_rd(bus.mem_inst) && w_mem_rd == w_rs1) ? bus.mem_alu : w_rd1;

  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                    w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'h000};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                    w_inst[20], w_inst[30:21], 1'b0};

  assign w_rd_idx    = bus.id_pc[IDX_BITS+1:2];
  assign w_up_idx    = bus.ex_br_pc[IDX_BITS+1:2];
  assign w_bht_taken = r_bht[w_rd_idx][CTR_BITS-1];

  always_comb begin
    w_imm  = '0;
    w_tgt  = bus.id_pc + 32'd4;
    w_pred = 1'b0;
    case (w_op)
      OP_JAL: begin
        w_imm  = w_imm_j;
        w_tgt  = bus.id_pc + w_imm_j;
        w_pred = 1'b1;
      end
      OP_JALR: begin
        w_imm  = w_imm_i;
        w_tgt  = (w_fwd + w_imm_i) & ~32'd1;
        w_pred = 1'b1;
      end
      OP_BR: begin
        w_imm  = w_imm_b;
        w_tgt  = bus.id_pc + w_imm_b;
        w_pred = w_bht_taken;
      end
      OP_LOAD, OP_IMM:   w_imm = w_imm_i;
      OP_STORE:          w_imm = w_imm_s;
      OP_LUI, OP_AUIPC:  w_imm = w_imm_u;
      default: ;
    endcase
  end

  assign bus.if_pc_target    = w_tgt;
  assign bus.if_target_taken = w_pred & ~w_bubble;
  assign bus.id_stall        = w_stall;

  // Training lands at the edge, so a same-cycle ID read sees the old count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
    end else if (bus.ex_br_valid) begin
      if (bus.ex_br_outcome && r_bht[w_up_idx] != CTR_MAX)
        r_bht[w_up_idx] <= r_bht[w_up_idx] + CTR_ONE;
      else if (!bus.ex_br_outcome && r_bht[w_up_idx] != '0)
        r_bht[w_up_idx] <= r_bht[w_up_idx] - CTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_pc       <= '0;
      r_ex_rd1      <= '0;
      r_ex_rd2      <= '0;
      r_ex_imm      <= '0;
      r_ex_inst     <= NOP;
      r_ex_br_taken <= 1'b0;
    end else if (w_bubble) begin
      r_ex_pc       <= '0;
      r_ex_rd1      <= '0;
      r_ex_rd2      <= '0;
      r_ex_imm      <= '0;
      r_ex_inst     <= NOP;
      r_ex_br_taken <= 1'b0;
    end else begin
      r_ex_pc       <= bus.id_pc;
      r_ex_rd1      <= w_rd1;
      r_ex_rd2      <= w_rd2;
      r_ex_imm      <= w_imm;
      r_ex_inst     <= w_inst;
      r_ex_br_taken <= w_pred;
    end
  end

  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_rd1      = r_ex_rd1;
  assign bus.ex_rd2      = r_ex_rd2;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.ex_inst     = r_ex_inst;
  assign bus.ex_br_taken = r_ex_br_taken;

  assign w_unused = ^{bus.wb_inst[31:12], bus.wb_inst[6:0],
                      bus.mem_inst[31:12], bus.ex_br_pc[31:IDX_BITS+2],
                      bus.ex_br_pc[1:0]};
endmodule

// File: tb/tb_id_bpred_stage.sv
// Bench for id_bpred_stage: vector table, directed corner sequences and
// random traffic against a field-level reference model.
module tb_id_bpred_stage;
  localparam int BHT = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int K_ADDI = 0, K_ADD = 1, K_LW = 2, K_SW = 3;
  localparam int K_BEQ = 4, K_JAL = 5, K_JALR = 6, K_LUI = 7;

  typedef struct {
    int          k;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ins_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] bios;
    logic [31:0] imem;
    logic [31:0] tgt;
    logic        tk;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  id_bpred_if bus ();

  id_bpred_stage #(
    .BHT_ENTRIES(BHT), .CTR_BITS(2), .INST_SEL_BIT(30)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int bht_m [BHT];
  logic [31:0] rf_m [32];
  ins_t ex_m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ins_t mk(input int k, input int rd, input int rs1,
                              input int rs2, input logic [31:0] imm);
    ins_t x;
    x.k = k; x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.imm = imm;
    return x;
  endfunction

  function automatic logic [31:0] enc(input ins_t x);
    logic [31:0] m;
    m = x.imm;
    case (x.k)
      K_ADDI: return {m[11:0], x.rs1, 3'b000, x.rd, 7'h13};
      K_ADD:  return {7'b0, x.rs2, x.rs1, 3'b000, x.rd, 7'h33};
      K_LW:   return {m[11:0], x.rs1, 3'b010, x.rd, 7'h03};
      K_SW:   return {m[11:5], x.rs2, x.rs1, 3'b010, m[4:0], 7'h23};
      K_BEQ:  return {m[12], m[10:5], x.rs2, x.rs1, 3'b000,
                      m[4:1], m[11], 7'h63};
      K_JAL:  return {m[20], m[10:1], m[11], m[19:12], x.rd, 7'h6f};
      K_JALR: return {m[11:0], x.rs1, 3'b000, x.rd, 7'h67};
      default: return {m[31:12], x.rd, 7'h37};
    endcase
  endfunction

  function automatic bit writes(input ins_t x);
    return x.rd != 0 && (x.k == K_ADDI || x.k == K_ADD || x.k == K_LW ||
                         x.k == K_JAL || x.k == K_JALR || x.k == K_LUI);
  endfunction

  function automatic bit use1(input int k);
    return k == K_ADDI || k == K_ADD || k == K_LW || k == K_SW ||
           k == K_BEQ || k == K_JALR;
  endfunction

  function automatic bit use2(input int k);
    return k == K_ADD || k == K_SW || k == K_BEQ;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [19:0] u20;
    x.k = int'($urandom_range(0, 7));
    x.rd = 5'($urandom_range(0, 3));
    x.rs1 = 5'($urandom_range(0, 3));
    x.rs2 = 5'($urandom_range(0, 3));
    i12 = 12'($urandom);
    b13 = 13'($urandom); b13[0] = 1'b0;
    j21 = 21'($urandom); j21[0] = 1'b0;
    u20 = 20'($urandom);
    case (x.k)
      K_ADDI, K_LW, K_SW, K_JALR: x.imm = {{20{i12[11]}}, i12};
      K_BEQ: x.imm = {{19{b13[12]}}, b13};
      K_JAL: x.imm = {{11{j21[20]}}, j21};
      K_LUI: x.imm = {u20, 12'h000};
      default: x.imm = '0;
    endcase
    return x;
  endfunction

  function automatic logic [31:0] pick(input int i);
    case (i)
      0: return 32'h0000_1000;
      1: return 32'h0000_1004;
      2: return 32'h0000_1100;
      default: return 32'h0000_1008;
    endcase
  endfunction

  function automatic logic [31:0] rval(input logic [4:0] r, input logic we,
                                       input logic [4:0] wr,
                                       input logic [31:0] wd);
    if (r == 0) return '0;
    if (we && wr == r) return wd;
    return rf_m[r];
  endfunction

  task automatic idle();
    bus.ex_flush = 0; bus.id_pc = '0;
    bus.id_bios_inst = NOP; bus.id_imem_inst = NOP;
    bus.wb_regwen = 0; bus.wb_inst = '0; bus.wb_wdata = '0;
    bus.ex_alu = '0; bus.mem_alu = '0; bus.mem_inst = NOP;
    bus.ex_br_valid = 0; bus.ex_br_pc = '0; bus.ex_br_outcome = 0;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] inst);
    bus.id_pc = pc; bus.id_bios_inst = inst; bus.id_imem_inst = inst;
  endtask

  task automatic train(input logic [31:0] pc, input logic o, input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      bus.ex_br_valid = 1; bus.ex_br_pc = pc; bus.ex_br_outcome = o;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic pred(input logic [31:0] pc, input string nm,
                      input logic exp);
    idle();
    put(pc, enc(mk(K_BEQ, 0, 1, 2, 32'hFFFF_FFF8)));
    #1;
    chk(nm, 32'(bus.if_target_taken), 32'(exp));
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic rand_step();
    ins_t x, mi, nx;
    logic [31:0] pc, inst, wbi, wd, ea, ma, bpc, base, tgt, r1, r2;
    logic src, wbw, fl, bv, bo, tk, st;
    int idx;
    x = rnd_ins(); mi = rnd_ins();
    src = 1'($urandom);
    pc = pick(int'($urandom_range(0, 3))) | {1'b0, src, 30'b0};
    inst = enc(x);
    wbw = 1'($urandom); wbi = $urandom;
    wbi[11:7] = 5'($urandom_range(0, 3)); wd = $urandom;
    fl = ($urandom_range(0, 7) == 0);
    bv = 1'($urandom); bo = 1'($urandom);
    bpc = pick(int'($urandom_range(0, 3)));
    ea = $urandom; ma = $urandom;
    bus.id_pc = pc;
    bus.id_bios_inst = src ? inst : $urandom;
    bus.id_imem_inst = src ? $urandom : inst;
    bus.wb_regwen = wbw; bus.wb_inst = wbi; bus.wb_wdata = wd;
    bus.ex_flush = fl; bus.ex_br_valid = bv;
    bus.ex_br_pc = bpc; bus.ex_br_outcome = bo;
    bus.ex_alu = ea; bus.mem_alu = ma; bus.mem_inst = enc(mi);
    r1 = rval(inst[19:15], wbw, wbi[11:7], wd);
    r2 = rval(inst[24:20], wbw, wbi[11:7], wd);
    st = (ex_m.k == K_LW && ex_m.rd != 0 &&
          ((use1(x.k) && x.rs1 == ex_m.rd) ||
           (use2(x.k) && x.rs2 == ex_m.rd))) ||
         (x.k == K_JALR && mi.k == K_LW && mi.rd != 0 && mi.rd == x.rs1);
    if (writes(ex_m) && ex_m.rd == x.rs1) base = ea;
    else if (writes(mi) && mi.rd == x.rs1) base = ma;
    else base = r1;
    tgt = pc + 32'd4; tk = 0;
    idx = int'((pc / 4) % BHT);
    if (x.k == K_JAL) begin tgt = pc + x.imm; tk = 1; end
    if (x.k == K_JALR) begin tgt = (base + x.imm) & ~32'd1; tk = 1; end
    if (x.k == K_BEQ) begin tgt = pc + x.imm; tk = bht_m[idx] >= 2; end
    #1;
    chk("rnd_target", bus.if_pc_target, tgt);
    chk("rnd_taken", 32'(bus.if_target_taken), 32'(tk && !st && !fl));
    chk("rnd_stall", 32'(bus.id_stall), 32'(st));
    @(posedge clk); #1;
    if (bv) begin
      idx = int'((bpc / 4) % BHT);
      if (bo && bht_m[idx] < 3) bht_m[idx]++;
      if (!bo && bht_m[idx] > 0) bht_m[idx]--;
    end
    if (wbw && wbi[11:7] != 0) rf_m[wbi[11:7]] = wd;
    if (st || fl) begin
      nx = mk(K_ADDI, 0, 0, 0, '0);
      pc = '0; r1 = '0; r2 = '0; inst = NOP; tk = 0;
    end else begin
      nx = x;
    end
    chk("rnd_ex_pc", bus.ex_pc, pc);
    chk("rnd_ex_rd1", bus.ex_rd1, r1);
    chk("rnd_ex_rd2", bus.ex_rd2, r2);
    chk("rnd_ex_imm", bus.ex_imm, nx.imm);
    chk("rnd_ex_inst", bus.ex_inst, inst);
    chk("rnd_ex_taken", 32'(bus.ex_br_taken), 32'(tk));
    ex_m = nx;
    @(negedge clk);
  endtask

  initial begin
    vec_t v [8];
    logic [31:0] bq, jl;
    idle();
    @(negedge clk);
    chk("rst_ex_inst", bus.ex_inst, NOP);
    chk("rst_ex_pc", bus.ex_pc, 32'h0);
    chk("rst_ex_taken", 32'(bus.ex_br_taken), 32'h0);
    chk("rst_ex_imm", bus.ex_imm, 32'h0);
    rst = 0;

    bq = enc(mk(K_BEQ, 0, 1, 2, 32'd16));
    jl = enc(mk(K_JAL, 1, 0, 0, 32'h40));
    v[0] = '{32'h1000, enc(mk(K_BEQ, 0, 1, 2, 32'hFFFF_FFF8)),
             enc(mk(K_BEQ, 0, 1, 2, 32'hFFFF_FFF8)), 32'h0FF8, 1'b0};
    v[1] = '{32'h2000, enc(mk(K_JAL, 1, 0, 0, 32'h100)),
             enc(mk(K_JAL, 1, 0, 0, 32'h100)), 32'h2100, 1'b1};
    v[2] = '{32'h0, enc(mk(K_JAL, 0, 0, 0, 32'hFFFF_FFFC)),
             enc(mk(K_JAL, 0, 0, 0, 32'hFFFF_FFFC)), 32'hFFFF_FFFC, 1'b1};
    v[3] = '{32'h500, enc(mk(K_JALR, 0, 0, 0, 32'h7FF)),
             enc(mk(K_JALR, 0, 0, 0, 32'h7FF)), 32'h07FE, 1'b1};
    v[4] = '{32'h3000, enc(mk(K_ADDI, 3, 0, 0, 32'd5)),
             enc(mk(K_ADDI, 3, 0, 0, 32'd5)), 32'h3004, 1'b0};
    v[5] = '{32'hFFFF_FFFC, enc(mk(K_LUI, 2, 0, 0, 32'h1234_5000)),
             enc(mk(K_LUI, 2, 0, 0, 32'h1234_5000)), 32'h0, 1'b0};
    v[6] = '{32'h4000_1000, bq, jl, 32'h4000_1010, 1'b0};
    v[7] = '{32'h0000_1000, jl, bq, 32'h0000_1010, 1'b0};
    for (int i = 0; i < 8; i++) begin
      idle();
      bus.id_pc = v[i].pc;
      bus.id_bios_inst = v[i].bios; bus.id_imem_inst = v[i].imem;
      #1;
      chk("vec_target", bus.if_pc_target, v[i].tgt);
      chk("vec_taken", 32'(bus.if_target_taken), 32'(v[i].tk));
      chk("vec_stall", 32'(bus.id_stall), 32'h0);
      @(posedge clk); #1;
      chk("vec_ex_inst", bus.ex_inst, v[i].pc[30] ? v[i].bios : v[i].imem);
      chk("vec_ex_pc", bus.ex_pc, v[i].pc);
      chk("vec_ex_taken", 32'(bus.ex_br_taken), 32'(v[i].tk));
      @(negedge clk);
    end

    train(32'h1000, 1, 2);
    idle();
    put(32'h1000, enc(mk(K_BEQ, 0, 1, 2, 32'hFFFF_FFF8)));
    #1;
    chk("sat_taken", 32'(bus.if_target_taken), 32'h1);
    chk("sat_target", bus.if_pc_target, 32'h0000_0FF8);
    @(negedge clk);
    train(32'h1000, 0, 4);
    train(32'h1000, 1, 1);
    pred(32'h1000, "sat_floor_hold", 1'b0);
    train(32'h1000, 1, 1);
    pred(32'h1000, "sat_floor_up2", 1'b1);

    do_reset();
    pred(32'h1000 + 4 * BHT, "alias_before", 1'b0);
    train(32'h1000, 1, 1);
    pred(32'h1000 + 4 * BHT, "alias_after", 1'b1);
    pred(32'h1000, "alias_self", 1'b1);

    idle();
    put(32'h100, enc(mk(K_ADDI, 1, 0, 0, 32'd5)));
    @(negedge clk);
    idle();
    put(32'h104, enc(mk(K_JALR, 0, 1, 0, 32'd4)));
    bus.ex_alu = 32'h2001;
    #1;
    chk("jalr_fwd_target", bus.if_pc_target, 32'h2004);
    chk("jalr_fwd_taken", 32'(bus.if_target_taken), 32'h1);
    @(negedge clk);
    idle();
    put(32'h108, enc(mk(K_LW, 1, 0, 0, 32'd0)));
    @(negedge clk);
    idle();
    put(32'h10C, enc(mk(K_JALR, 0, 1, 0, 32'd4)));
    #1;
    chk("lu_stall", 32'(bus.id_stall), 32'h1);
    chk("lu_taken", 32'(bus.if_target_taken), 32'h0);
    @(posedge clk); #1;
    chk("lu_bubble", bus.ex_inst, NOP);
    @(negedge clk);
    idle();
    put(32'h110, enc(mk(K_JALR, 0, 2, 0, 32'd0)));
    bus.mem_inst = enc(mk(K_LW, 2, 0, 0, 32'd0));
    #1;
    chk("mem_lu_stall", 32'(bus.id_stall), 32'h1);
    @(negedge clk);

    idle();
    put(32'h200, enc(mk(K_ADD, 3, 5, 0, 32'd0)));
    bus.wb_regwen = 1; bus.wb_inst = enc(mk(K_ADDI, 5, 0, 0, 32'd0));
    bus.wb_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("wb_bypass", bus.ex_rd1, 32'hDEAD_BEEF);
    @(negedge clk);
    idle();
    put(32'h204, enc(mk(K_ADD, 3, 5, 0, 32'd0)));
    @(posedge clk); #1;
    chk("wb_stored", bus.ex_rd1, 32'hDEAD_BEEF);
    @(negedge clk);
    idle();
    put(32'h208, enc(mk(K_ADD, 3, 0, 0, 32'd0)));
    bus.wb_regwen = 1; bus.wb_inst = enc(mk(K_ADDI, 0, 0, 0, 32'd0));
    bus.wb_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("wb_x0", bus.ex_rd1, 32'h0);
    @(negedge clk);

    idle();
    put(32'h300, enc(mk(K_JAL, 1, 0, 0, 32'd8)));
    bus.ex_flush = 1;
    #1;
    chk("flush_taken", 32'(bus.if_target_taken), 32'h0);
    @(posedge clk); #1;
    chk("flush_inst", bus.ex_inst, NOP);
    chk("flush_pc", bus.ex_pc, 32'h0);
    chk("flush_taken_ex", 32'(bus.ex_br_taken), 32'h0);
    @(negedge clk);

    train(32'h1000, 1, 2);
    idle();
    put(32'h300, enc(mk(K_JAL, 1, 0, 0, 32'd8)));
    @(posedge clk); #2;
    chk("pre_rst_inst", bus.ex_inst, enc(mk(K_JAL, 1, 0, 0, 32'd8)));
    rst = 1;
    #1;
    chk("async_rst_inst", bus.ex_inst, NOP);
    chk("async_rst_pc", bus.ex_pc, 32'h0);
    @(negedge clk);
    rst = 0;
    pred(32'h1000, "rst_bht_init", 1'b0);
    train(32'h1000, 1, 1);
    pred(32'h1000, "rst_bht_one_up", 1'b1);
    idle();
    rst = 1;
    bus.ex_br_valid = 1; bus.ex_br_pc = 32'h1000; bus.ex_br_outcome = 1;
    @(negedge clk);
    rst = 0;
    pred(32'h1000, "rst_beats_train", 1'b0);

    do_reset();
    for (int r = 1; r < 32; r++) begin
      idle();
      bus.wb_regwen = 1; bus.wb_inst = {20'h0, 5'(r), 7'h13};
      bus.wb_wdata = $urandom;
      rf_m[r] = bus.wb_wdata;
      @(negedge clk);
    end
    rf_m[0] = '0;
    for (int i = 0; i < BHT; i++) bht_m[i] = 1;
    ex_m = mk(K_ADDI, 0, 0, 0, '0);
    for (int i = 0; i < 400; i++) rand_step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
